// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder: class and ALU op
// codes, opcode/func3/func7 fields, the NOP word and FSM state type.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        CLS_R     = 3'b000,
        CLS_I     = 3'b001,
        CLS_LOAD  = 3'b010,
        CLS_STORE = 3'b011
    } instr_class_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [2:0]  F3_WORD    = 3'b010;
    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_SUB     = 7'b0010100;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    function automatic logic [2:0] alu_func3(input logic [2:0] op);
        logic [2:0] f3;
        f3 = 3'b000;
        case (op)
            ALU_ADD: f3 = 3'b000;
            ALU_SUB: f3 = 3'b000;
            ALU_XOR: f3 = 3'b100;
            ALU_OR:  f3 = 3'b110;
            ALU_AND: f3 = 3'b111;
            ALU_SLL: f3 = 3'b001;
            ALU_SRL: f3 = 3'b101;
            ALU_SLT: f3 = 3'b010;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous output FIFO holding encoded words; power-of-two depth, so the
// pointers wrap by natural overflow.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field bundles into 32-bit instruction words and streams them out
// with consecutive byte addresses through a small FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_class,
    input  logic [2:0]             in_alu_op,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [31:0]            in_imm,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic                   err
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e      state_q;
    state_e      state_d;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        imm12_ok;
    logic        shamt_ok;
    logic [2:0]  f3;

    assign in_ready  = (state_q == ST_RUN) && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign imm12_ok = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
    assign shamt_ok = (in_imm[31:5] == '0);
    assign f3       = alu_func3(in_alu_op);

    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b0;
        case (in_class)
            CLS_R: begin
                enc_word = {(in_alu_op == ALU_SUB) ? F7_SUB : F7_BASE,
                            in_rs2, in_rs1, f3, in_rd, OPC_OP};
            end
            CLS_I: begin
                if (in_alu_op == ALU_SLL || in_alu_op == ALU_SRL) begin
                    enc_word = {7'b0000000, in_imm[4:0], in_rs1, f3, in_rd, OPC_OP_IMM};
                    enc_err  = !shamt_ok;
                end else begin
                    // SUB has no immediate form; its func3 maps to ADD, giving ADDI.
                    enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OP_IMM};
                    enc_err  = !imm12_ok || (in_alu_op == ALU_SUB);
                end
            end
            CLS_LOAD: begin
                enc_word = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OPC_LOAD};
                enc_err  = !imm12_ok;
            end
            CLS_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OPC_STORE};
                enc_err  = !imm12_ok;
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (enc_word),
        .rdata  (out_instr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (push && in_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && count == CW'(1)) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            out_addr <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                out_addr <= base_addr;
                err      <= 1'b0;
            end else if (pop) begin
                out_addr <= out_addr + 32'd4;
            end
            if (push && enc_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding vector table plus hand sequences for
// back-pressure, drain/done and reset-during-drain; output via scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        done;
    logic        err;

    instr_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_alu_op (in_alu_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] sb [$];
    logic [31:0] cur_exp;
    logic [31:0] exp_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accepted beat, pop and compare on each output pop.
    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("out_instr", out_instr, sb.pop_front());
                    chk("out_addr", out_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
            end
            if (in_valid && in_ready)
                sb.push_back(cur_exp);
        end
    end

    task automatic do_start(input logic [31:0] base);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        exp_addr  = base;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [2:0] cls, input logic [2:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             input logic [31:0] exp, input logic last);
        bit got;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_class  = cls;
        in_alu_op = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
        cur_exp   = exp;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got)
            chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input logic [2:0] exp_count_at_done);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_count", 32'(count), 32'(exp_count_at_done));
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd);
        return 32'h0020_8033 | (32'(rd) << 7);
    endfunction

    initial begin
        vecs[0]  = '{3'd0, 3'd0, 5'd3,  5'd1,  5'd2,  32'd0,        32'h002081B3, 1'b0};
        vecs[1]  = '{3'd0, 3'd1, 5'd3,  5'd1,  5'd2,  32'd0,        32'h282081B3, 1'b0};
        vecs[2]  = '{3'd0, 3'd4, 5'd10, 5'd11, 5'd12, 32'd0,        32'h00C5F533, 1'b0};
        vecs[3]  = '{3'd0, 3'd7, 5'd1,  5'd2,  5'd3,  32'd0,        32'h003120B3, 1'b0};
        vecs[4]  = '{3'd1, 3'd0, 5'd5,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFF00293, 1'b0};
        vecs[5]  = '{3'd1, 3'd5, 5'd5,  5'd0,  5'd0,  32'd40,       32'h00801293, 1'b1};
        vecs[6]  = '{3'd1, 3'd6, 5'd7,  5'd8,  5'd0,  32'd31,       32'h01F45393, 1'b0};
        vecs[7]  = '{3'd1, 3'd1, 5'd1,  5'd1,  5'd0,  32'd5,        32'h00508093, 1'b1};
        vecs[8]  = '{3'd1, 3'd2, 5'd2,  5'd3,  5'd0,  32'd2047,     32'h7FF1C113, 1'b0};
        vecs[9]  = '{3'd1, 3'd3, 5'd2,  5'd3,  5'd0,  32'd2048,     32'h8001E113, 1'b1};
        vecs[10] = '{3'd1, 3'd4, 5'd4,  5'd4,  5'd0,  32'hFFFFF800, 32'h80027213, 1'b0};
        vecs[11] = '{3'd2, 3'd0, 5'd9,  5'd2,  5'd31, 32'd16,       32'h01012483, 1'b0};
        vecs[12] = '{3'd3, 3'd0, 5'd31, 5'd2,  5'd6,  32'd8,        32'h00612423, 1'b0};
        vecs[13] = '{3'd3, 3'd0, 5'd0,  5'd1,  5'd1,  32'hFFFFFFFC, 32'hFE10AE23, 1'b0};
        vecs[14] = '{3'd2, 3'd0, 5'd1,  5'd1,  5'd0,  32'd4096,     32'h0000A083, 1'b1};
        vecs[15] = '{3'd4, 3'd0, 5'd0,  5'd0,  5'd0,  32'd0,        32'h00000013, 1'b1};
        vecs[16] = '{3'd7, 3'd3, 5'd5,  5'd5,  5'd5,  32'd123,      32'h00000013, 1'b1};
        vecs[17] = '{3'd1, 3'd6, 5'd1,  5'd1,  5'd0,  32'hFFFFFFFF, 32'h01F0D093, 1'b1};

        resetn = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_class = '0; in_alu_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_last = 1'b0; out_ready = 1'b1; cur_exp = '0; exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_ready", 32'(in_ready), 32'd0);

        // Encoding table: one single-beat program per vector.
        for (int i = 0; i < 18; i++) begin
            do_start(32'h1000 + 32'(i) * 32'h40);
            chk("start_clears_err", 32'(err), 32'd0);
            chk("run_in_ready", 32'(in_ready), 32'd1);
            send_beat(vecs[i].cls, vecs[i].op, vecs[i].rd, vecs[i].rs1,
                      vecs[i].rs2, vecs[i].imm, vecs[i].exp_instr, 1'b1);
            chk("vec_err", 32'(err), 32'(vecs[i].exp_err));
            chk("latency_valid", 32'(out_valid), 32'd1);
            wait_done(3'd1);
        end

        // Sticky error across later legal beats.
        do_start(32'h2000);
        send_beat(3'd1, 3'd5, 5'd5, 5'd0, 5'd0, 32'd40, 32'h00801293, 1'b0);
        chk("sticky_set", 32'(err), 32'd1);
        send_beat(3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        send_beat(3'd0, 3'd0, 5'd4, 5'd1, 5'd2, 32'd0, r_add(5'd4), 1'b1);
        chk("sticky_hold", 32'(err), 32'd1);
        wait_done(3'd1);

        // Back-pressure: fill FIFO, ignored restart, then release.
        do_start(32'h200);
        chk("restart_clears_err", 32'(err), 32'd0);
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++)
            send_beat(3'd0, 3'd0, 5'(k), 5'd1, 5'd2, 32'd0, r_add(5'(k)), 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'hDEAD0000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start_addr", out_addr, 32'h200);
        out_ready = 1'b1;
        send_beat(3'd0, 3'd0, 5'd5, 5'd1, 5'd2, 32'd0, r_add(5'd5), 1'b1);
        chk("simul_count", 32'(count), 32'd3);
        wait_done(3'd1);
        chk("bp_final_addr", out_addr, 32'h214);

        // Three-beat program, done on the third pop.
        do_start(32'h300);
        send_beat(3'd0, 3'd0, 5'd7, 5'd1, 5'd2, 32'd0, r_add(5'd7), 1'b0);
        send_beat(3'd0, 3'd0, 5'd8, 5'd1, 5'd2, 32'd0, r_add(5'd8), 1'b0);
        send_beat(3'd0, 3'd0, 5'd9, 5'd1, 5'd2, 32'd0, r_add(5'd9), 1'b1);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        wait_done(3'd1);

        // Reset during DRAIN discards queued words.
        do_start(32'h400);
        out_ready = 1'b0;
        send_beat(3'd0, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0, r_add(5'd1), 1'b0);
        send_beat(3'd0, 3'd0, 5'd2, 5'd1, 5'd2, 32'd0, r_add(5'd2), 1'b0);
        send_beat(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_err", 32'(err), 32'd1);
        resetn = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_addr", out_addr, 32'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(in_ready), 32'd0);
        do_start(32'hFFFF_FFFC);
        send_beat(3'd0, 3'd0, 5'd6, 5'd1, 5'd2, 32'd0, r_add(5'd6), 1'b0);
        send_beat(3'd0, 3'd0, 5'd7, 5'd1, 5'd2, 32'd0, r_add(5'd7), 1'b1);
        wait_done(3'd1);
        chk("wrap_addr", out_addr, 32'h0000_0004);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port resetn  in  1  reset; resetn is synchronous, active-low.
REQ-004 SHALL have port start  in  1  load out_addr counter from base_addr and enter RUN.
REQ-005 SHALL have port base_addr  in  32  first instruction-memory byte address.
REQ-006 SHALL have port in_valid / in_ready  in / out  1 / 1  field-bundle handshake.
REQ-007 SHALL have port in_class  in  3  000 R-type, 001 I-ALU, 010 LOAD, 011 STORE, others invalid.
REQ-008 SHALL have port in_alu_op  in  3  000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 SLL, 110 SRL, 111 SLT.
REQ-009 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-010 SHALL have port in_imm  in  32  signed immediate.
REQ-011 SHALL have port in_last  in  1  marks final instruction of program.
REQ-012 SHALL have ports out_valid / out_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-013 SHALL have ports out_instr, out_addr  out  32 each  encoded word and its byte address.
REQ-014 SHALL have ports count  out  $clog2(DEPTH)+1  FIFO occupancy; done  out  1  one-cycle pulse; err  out  1  sticky encode error.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on accepted beat with in_last=1; DRAIN->IDLE when last entry popped, done=1 that cycle only.
REQ-016 in_ready = (state==RUN) && count<DEPTH; no push when full or outside RUN.
REQ-017 Accepted beat encoded combinationally, written to FIFO same edge; out_valid=1 next cycle (latency 1).
REQ-018 out_valid = count!=0; pop on out_valid&&out_ready; out_addr increments by 4 per pop, wraps modulo 2^32.
REQ-019 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-020 start in RUN/DRAIN: ignored; start in IDLE with pop same cycle: out_addr<=base_addr (start wins).
REQ-021 R-type: opcode 0110011; func3 per alu_op 000/000/100/110/111/001/101/010; func7 0000000 except SUB = 0010100.
REQ-022 I-ALU: opcode 0010011, same func3 map; imm[11:0] in [31:20]; SUB illegal -> err, encode as ADDI.
REQ-023 I-ALU shifts (101,110): [24:20]=imm[4:0], [31:25]=0; err if imm outside 0..31.
REQ-024 I-ALU non-shift: err if imm outside -2048..2047; low 12 bits still encoded.
REQ-025 LOAD: opcode 0000011, func3 010, rd, rs1, imm[11:0]; STORE: opcode 0100011, func3 010, [31:25]=imm[11:5], [11:7]=imm[4:0], rs2, rs1; same range check.
REQ-026 Invalid in_class: err, encode NOP 0x00000013.
REQ-027 err set on offending beat's accept edge, cleared only by reset or start.

Reset
REQ-028 resetn=0 at edge: state IDLE, count 0, pointers 0, out_addr 0, err 0, done 0, in_ready 0, out_valid 0; mid-DRAIN reset discards FIFO contents.

Structure
REQ-029 Shared package holds class codes, alu_op codes, opcode/func3/func7 constants, NOP constant.
REQ-030 One sub-module instr_fifo (synchronous FIFO, DEPTH, 32-bit data, push/pop/count).

Verification
REQ-031 start base 0x100, R ADD rd=3 rs1=1 rs2=2 -> out_instr 0x002081B3, out_addr 0x100, next cycle.
REQ-032 I-ALU ADD rd=5 rs1=0 imm=-1 -> 0xFFF00293, err=0; SLL imm=40 -> err=1 sticky.
REQ-033 STORE rs2=6 rs1=2 imm=8 -> 0x00612423; invalid class 100 -> 0x00000013, err=1.
REQ-034 out_ready=0, push 5 beats with DEPTH=4 -> in_ready=0 after 4, count=4; release -> addresses base, +4, +8, +12, +16 in order.
REQ-035 in_last on 3rd beat -> DRAIN, in_ready=0, done pulses on 3rd pop; reset asserted mid-DRAIN -> count=0, out_valid=0, IDLE next cycle.
